// File: rtl/simple_rr_packet_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// simple_rr_packet_arbiter_pkg
// Shared constants and helpers for the round-robin packet arbiter.
//   DEFAULT_N  : default number of requesters.
//   idx_width  : index width for N requesters (clog2, never below 1).
// The index type itself depends on N, so each user declares it locally as
//   typedef logic [idx_width(N)-1:0] idx_t;
// -----------------------------------------------------------------------------
package simple_rr_packet_arbiter_pkg;

  localparam int DEFAULT_N = 8;

  // Width of a requester index; a 1-bit index is kept even for tiny N.
  function automatic int idx_width(input int n);
    int w;
    if (n <= 2) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/simple_rr_packet_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin pick: finds the first set bit of req at or after
// index start, wrapping modulo N.
// Ports:
//   req        in  N   request vector
//   start      in  IW  index where the search begins (highest priority)
//   winner     out N   one-hot winner, zero when req is zero
//   winner_idx out IW  index of the winner, zero when req is zero
//   valid      out 1   high when any request is present
// The wrap is handled by searching the doubled vector {req, req} with every
// bit below start masked off; a hit in the upper copy maps back by -N.
// -----------------------------------------------------------------------------
module rr_priority_picker
  import simple_rr_packet_arbiter_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx,
  output logic          valid
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;

  // Masked double-width priority encoder.
  always_comb begin
    dbl        = {req, req};
    mask       = '0;
    valid      = 1'b0;
    winner_idx = '0;
    winner     = '0;
    for (int j = 0; j < 2*N; j++) begin
      mask[j] = (j >= int'(start));
    end
    masked = dbl & mask;
    for (int j = 0; j < 2*N; j++) begin
      if (masked[j] && !valid) begin
        valid      = 1'b1;
        winner_idx = (j >= N) ? IW'(j - N) : IW'(j);
      end else begin
        valid      = valid;
      end
    end
    if (valid) begin
      winner[winner_idx] = 1'b1;
    end else begin
      winner = '0;
    end
  end

endmodule

// File: rtl/simple_rr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// simple_rr_packet_arbiter
// N-requester round-robin arbiter with packet locking. A granted requester
// keeps the grant until the beat flagged by req_is_last; priority then rotates
// past it. If a locked owner drops its request, the cycle is arbitrated as if
// unlocked.
// Ports:
//   clk          in  1  rising-edge clock
//   rst          in  1  synchronous active-high reset
//   req          in  N  per-requester request
//   req_is_last  in  N  last-beat flag, only meaningful for the granted bit
//   grants       out N  one-hot-or-zero grant, combinational (same-cycle)
// Optional build macro SIMPLE_RR_PACKET_ARBITER_ASSERT_EN compiles in the
// simple_rr_packet_arbiter_checker module (concurrent assertions).
// -----------------------------------------------------------------------------
module simple_rr_packet_arbiter
  import simple_rr_packet_arbiter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] req_is_last,
  output logic [N-1:0] grants
);

  localparam int IW = idx_width(N);
  typedef logic [IW-1:0] idx_t;
  localparam idx_t LAST_INIT = idx_t'(N - 1);

  logic         locked;
  idx_t         owner;
  idx_t         last;
  idx_t         start;
  idx_t         gidx;
  idx_t         pick_idx;
  logic [N-1:0] pick_winner;
  logic         pick_valid;
  logic [N-1:0] owner_hot;

  // Search begins one past the most recently completed owner.
  always_comb begin
    if (last == LAST_INIT) begin
      start = '0;
    end else begin
      start = idx_t'(last + idx_t'(1));
    end
  end

  rr_priority_picker #(
    .N  (N),
    .IW (IW)
  ) u_picker (
    .req        (req),
    .start      (start),
    .winner     (pick_winner),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // Grant mux: a live lock wins, otherwise the round-robin pick.
  always_comb begin
    owner_hot        = '0;
    owner_hot[owner] = 1'b1;
    grants           = '0;
    gidx             = '0;
    if (rst) begin
      grants = '0;
      gidx   = '0;
    end else if (locked && req[owner]) begin
      grants = owner_hot;
      gidx   = owner;
    end else if (pick_valid) begin
      grants = pick_winner;
      gidx   = pick_idx;
    end else begin
      grants = '0;
      gidx   = '0;
    end
  end

  // Lock, owner and rotation state update.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked <= 1'b0;
      owner  <= '0;
      last   <= LAST_INIT;
    end else if (|grants) begin
      if (req_is_last[gidx]) begin
        locked <= 1'b0;
        last   <= gidx;
      end else begin
        locked <= 1'b1;
        owner  <= gidx;
      end
    end else begin
      locked <= 1'b0;
    end
  end

`ifdef SIMPLE_RR_PACKET_ARBITER_ASSERT_EN
  simple_rr_packet_arbiter_checker #(
    .N  (N),
    .IW (IW)
  ) u_checker (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_is_last (req_is_last),
    .grants      (grants),
    .locked      (locked),
    .last        (last)
  );
`endif

endmodule

`ifdef SIMPLE_RR_PACKET_ARBITER_ASSERT_EN
// -----------------------------------------------------------------------------
// simple_rr_packet_arbiter_checker
// Concurrent properties of the arbiter, all disabled while rst is high.
// -----------------------------------------------------------------------------
module simple_rr_packet_arbiter_checker #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input logic          clk,
  input logic          rst,
  input logic [N-1:0]  req,
  input logic [N-1:0]  req_is_last,
  input logic [N-1:0]  grants,
  input logic          locked,
  input logic [IW-1:0] last
);

  a_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grants));
  a_subset  : assert property (@(posedge clk) disable iff (rst) (grants & ~req) == '0);

  for (genvar i = 0; i < N; i++) begin : g_bit
    a_hold : assert property (@(posedge clk) disable iff (rst)
      (grants[i] && !req_is_last[i]) |=> (!req[i] || grants[i]));
    a_rotate : assert property (@(posedge clk) disable iff (rst)
      (grants[i] && req_is_last[i]) |=> (!locked && last == IW'(i)));
  end

endmodule
`endif

// File: tb/tb_simple_rr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_simple_rr_packet_arbiter
// Directed scenarios checked against fixed expected grants, then randomized
// traffic checked against a behavioural round-robin model.
// -----------------------------------------------------------------------------
module tb_simple_rr_packet_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] req_is_last;
  logic [N-1:0] grants;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state.
  bit           m_locked;
  int           m_owner;
  int           m_last;
  logic [N-1:0] exp_grants;

  localparam logic [7:0] P_REQ  [12] = '{8'h9B, 8'h9B, 8'h9A, 8'h9A, 8'h99, 8'h99,
                                         8'h91, 8'hB1, 8'hA1, 8'hA1, 8'hA1, 8'h00};
  localparam logic [7:0] P_LAST [12] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h08,
                                         8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [7:0] P_EXP  [12] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h08, 8'h08,
                                         8'h10, 8'h10, 8'h20, 8'h20, 8'h20, 8'h00};

  simple_rr_packet_arbiter #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_is_last (req_is_last),
    .grants      (grants)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_last   = N - 1;
  endtask

  // Hold rst high across the next rising edge with all requests asserted.
  task automatic assert_rst();
    @(negedge clk);
    rst         = 1'b1;
    req         = '1;
    req_is_last = '1;
    model_reset();
  endtask

  // Drive one beat, settle, compute the model's grant and advance the model.
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l);
    int g;
    @(negedge clk);
    rst         = 1'b0;
    req         = r;
    req_is_last = l;
    #1;
    g          = -1;
    exp_grants = '0;
    if (m_locked && r[m_owner]) begin
      g = m_owner;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && r[(m_last + k) % N]) g = (m_last + k) % N;
      end
    end
    if (g >= 0) begin
      exp_grants[g] = 1'b1;
      if (l[g]) begin
        m_locked = 1'b0;
        m_last   = g;
      end else begin
        m_locked = 1'b1;
        m_owner  = g;
      end
    end else begin
      m_locked = 1'b0;
    end
  endtask

  task automatic test_reset();
    assert_rst();
    #1;
    vectors++;
    if (grants !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_grants: got %b want %b", grants, 8'h00);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (grants !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hold: got %b want %b", grants, 8'h00);
    end
  endtask

  task automatic test_plan_sequence();
    assert_rst();
    for (int i = 0; i < 12; i++) begin
      drive(P_REQ[i], P_LAST[i]);
      vectors++;
      if (grants !== P_EXP[i]) begin
        miscompares++;
        $display("FAIL plan_step%0d: req=%b last=%b got %b want %b",
                 i, P_REQ[i], P_LAST[i], grants, P_EXP[i]);
      end
    end
  endtask

  task automatic test_single_beat_rotation();
    logic [7:0] want;
    assert_rst();
    for (int i = 0; i < 9; i++) begin
      drive(8'hFF, 8'hFF);
      want = 8'h01 << (i % 8);
      vectors++;
      if (grants !== want) begin
        miscompares++;
        $display("FAIL rotate_%0d: got %b want %b", i, grants, want);
      end
    end
  endtask

  task automatic test_abandon_and_idle();
    assert_rst();
    drive(8'h02, 8'h02);   // single beat by 1, last becomes 1
    drive(8'h04, 8'h00);   // 2 locks
    vectors++;
    if (grants !== 8'h04) begin
      miscompares++;
      $display("FAIL abandon_lock: got %b want %b", grants, 8'h04);
    end
    drive(8'h11, 8'h00);   // owner 2 drops, search from 2 -> 4
    vectors++;
    if (grants !== 8'h10) begin
      miscompares++;
      $display("FAIL abandon_rearb: got %b want %b", grants, 8'h10);
    end
    drive(8'h00, 8'hFF);   // idle drops the lock on 4, last stays 1
    vectors++;
    if (grants !== 8'h00) begin
      miscompares++;
      $display("FAIL idle_zero: got %b want %b", grants, 8'h00);
    end
    drive(8'hFF, 8'h00);   // search still starts at 2
    vectors++;
    if (grants !== 8'h04) begin
      miscompares++;
      $display("FAIL idle_keeps_last: got %b want %b", grants, 8'h04);
    end
    assert_rst();          // reset while 2 is locked
    #1;
    vectors++;
    if (grants !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_while_locked: got %b want %b", grants, 8'h00);
    end
    drive(8'hFF, 8'h00);
    vectors++;
    if (grants !== 8'h01) begin
      miscompares++;
      $display("FAIL after_rst: got %b want %b", grants, 8'h01);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] l;
    int           waits [N];
    int           max_wait;
    bit           done_other;
    r        = '0;
    max_wait = 0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    assert_rst();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) r[i] = ($urandom_range(7) != 0);
        else      r[i] = ($urandom_range(1) != 0);
        l[i] = ($urandom_range(3) == 0);
      end
      drive(r, l);
      vectors++;
      if (grants !== exp_grants) begin
        miscompares++;
        $display("FAIL random_c%0d: req=%b last=%b got %b want %b",
                 c, r, l, grants, exp_grants);
      end
      done_other = |(grants & l);
      for (int i = 0; i < N; i++) begin
        if (!r[i] || grants[i]) waits[i] = 0;
        else if (done_other) waits[i]++;
        if (waits[i] > max_wait) max_wait = waits[i];
      end
    end
    vectors++;
    if (max_wait > N - 1) begin
      miscompares++;
      $display("FAIL fairness: got %0d packets waited want at most %0d", max_wait, N - 1);
    end
  endtask

  initial begin
    rst         = 1'b1;
    req         = '0;
    req_is_last = '0;
    model_reset();
    test_reset();
    test_plan_sequence();
    test_single_beat_rotation();
    test_abandon_and_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/simple_rr_packet_arbiter.md
Name: simple_rr_packet_arbiter

Overview:
- N-requester round-robin arbiter with packet locking.
- Once a requester is granted, it owns the grant every cycle until the cycle in which its req_is_last bit is high.
- Ownership then releases and priority rotates past the last owner.
- Sits in front of a shared sink, e.g. an output port or bus, muxed by the one-hot grants vector.

Parameters:
- N, 8, number of requesters (N >= 2); sets the width of req, req_is_last and grants.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request; bit i high = requester i has a beat to send this cycle.
- req_is_last  in  N  bit i high = the current beat of requester i is the last beat of its packet. Don't-care when req[i] is low or i is not granted.
- grants  out  N  one-hot-or-zero grant; combinational from current state and req (same-cycle grant).

Behaviour:
- State:
  - locked flag.
  - owner index, log2(N) bits.
  - last index, log2(N) bits = most recently completed owner.
- Reset (rst high at a rising edge): locked=0, last=N-1, so requester 0 has top priority first. While rst is high, grants=0.
- Unlocked arbitration (combinational): search req starting at index last+1, wrapping modulo N. The first set bit wins and grants gets that single bit. If req=0, grants=0.
- Locked cycle with req[owner]=1: grants = only bit owner. All other requests are ignored.
- Locked cycle with req[owner]=0 (owner abandoned its packet): treated as unlocked. Arbitrate normally in the same cycle; the abandoned owner is not favoured.
- Update at each clock edge, when grants has bit g set:
  - If req_is_last[g]=1: locked<=0, last<=g (packet done; rotation advances).
  - Else: locked<=1, owner<=g.
- Update when grants=0: locked<=0; last unchanged.
- Single-beat packets (req_is_last high on the first granted beat) never set locked. Each such cycle rotates to the next requester.
- Output invariants:
  - grants is $onehot0.
  - grants is a subset of req.
  - grants is never X once out of reset, even if req_is_last is X on non-granted bits.
- Latency: zero cycles from req to grant; lock/release take effect at the next edge.
- Mid-operation reset drops any lock and returns priority to requester 0.

Optional Feature:
- Macro: SIMPLE_RR_PACKET_ARBITER_ASSERT_EN.
- When defined, concurrent SVA checks are compiled in, all disabled during rst:
  - grants is $onehot0.
  - (grants & ~req)==0.
  - A locked owner keeps its grant while req[owner] is high.
  - A granted bit with req_is_last high is followed by a rotation.
- When undefined, there are no assertions and the RTL is otherwise identical.

Decomposition:
- Package simple_rr_packet_arbiter_pkg holds:
  - Default N constant.
  - Helper function clog2-safe index width, with minimum 1.
  - Typedef for the index type, parameterised via N at the use site.
- One natural sub-module: rr_priority_picker, a combinational block taking req vector and start index, returning a one-hot winner plus its index. It is built as a double-width masked priority encoder.
- The top holds the lock/owner/last registers and the grant mux.

Test Plan:
- Reset then req=10011011, req_is_last=0 -> grants=00000001 (locks 0). Next cycle, same req with last=00000001 -> 00000001, then lock releases.
- Continue:
  - req=10011010, last=0 -> 00000010.
  - last=00000010 -> 00000010.
  - req=10011001, last=0 -> 00001000.
  - last=00001000 -> 00001000.
  - req=10010001 -> 00010000.
  - req=10110001, last=00010000 -> 00010000.
  - Then req=10100001, last=0 for 3 cycles -> 00100000 held all 3 cycles (lock on 5 despite bit 0 and bit 7 pending).
- Reset, req=11111111, req_is_last=11111111 for 8 cycles -> grants 00000001, 00000010, 00000100 ... 10000000, then wraps to 00000001.
- Locked owner drops req mid-packet: owner 2 locked, then req[2]=0 with req=00010001 -> grants=00010000 the same cycle (search from last+1).
- req=0 any cycle -> grants=0 and no state change to last. rst asserted while locked -> grants=0; after release, req=11111111 -> 00000001.
- Randomised req/req_is_last with ASSERT_EN defined -> no assertion failures; every continuously requesting requester is granted within N packets.
